rvh_l1d_lst_wr_sched: RTL and testbench
=======================================

# rvh_l1d_lst_wr_sched

Write scheduler for the L1D line-state table (LST). It merges MESI state updates from the core-side requesters (MLFB refill, store upgrade, eviction) and from the snoop engine onto the LST's two write ports. It guarantees that at most one LST write enable is asserted per cycle, because the LST shares one write-data mux across both ports. Snoop traffic has priority, with bounded starvation of the core side. Core requesters are served round-robin.

## Interface
Parameters:
- REQ_NUM, 3, number of core-side requesters (0 = MLFB refill, 1 = store upgrade, 2 = eviction)
- SET_IDX_W, 6, set-index width (L1D bank set count 64)
- WAY_IDX_W, 2, way-index width (4 ways)
- STARVE_MAX, 4, consecutive snoop grants allowed while a core request waits

Ports (clock domain: one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  REQ_NUM  core request valid, one bit per requester
- req_ready  out  REQ_NUM  core grant, one-hot or zero, combinational
- req_set_idx  in  REQ_NUM*SET_IDX_W  per-requester set index
- req_way_idx  in  REQ_NUM*WAY_IDX_W  per-requester way index
- req_mesi  in  REQ_NUM*2  per-requester new MESI state (2'd0 = I)
- snp_valid  in  1  snoop write valid
- snp_ready  out  1  snoop grant, combinational
- snp_set_idx  in  SET_IDX_W  snoop set index
- snp_way_idx  in  WAY_IDX_W  snoop way index
- snp_mesi  in  2  snoop new MESI state
- lst_mesi_wr_en_s0_req  out  1  registered core write enable
- lst_mesi_wr_set_idx_s0_req  out  SET_IDX_W  registered
- lst_mesi_wr_way_idx_s0_req  out  WAY_IDX_W  registered
- lst_mesi_wr_dat_s0_req  out  2  registered
- lst_mesi_wr_en_snp  out  1  registered snoop write enable
- lst_mesi_wr_set_idx_snp  out  SET_IDX_W  registered
- lst_mesi_wr_way_idx_snp  out  WAY_IDX_W  registered
- lst_mesi_wr_dat_snp  out  2  registered
- sched_busy  out  1  any valid pending, or any write enable registered

## Operation
- Handshake: a transfer occurs when valid & ready. Requesters hold valid and payload stable until ready. Ready never depends on payload.
- At most one grant per cycle across snp_ready and all req_ready bits.
- Arbitration:
  - If snp_valid and (no req_valid, or starve_cnt < STARVE_MAX): grant snoop.
  - Otherwise, if any req_valid: grant the core requester selected by round-robin.
- Round-robin: pointer rr_ptr names the highest-priority requester. The search starts at rr_ptr and wraps modulo REQ_NUM. After a core grant to requester k, rr_ptr = (k+1) mod REQ_NUM. It is unchanged on a snoop grant or an idle cycle.
- starve_cnt: 3-bit saturating counter.
  - Increments on a snoop grant while any req_valid is high.
  - Clears on any core grant, or when req_valid == 0.
  - When starve_cnt == STARVE_MAX and req_valid != 0, the core wins even if snp_valid is high.
- Same set/way on both sides in one cycle: the normal priority rule applies, and the loser stays pending. No merging.
- Output stage:
  - A granted request is registered into the matching LST port set (snoop → *_snp, core → *_s0_req), with wr_en = 1 for exactly one cycle.
  - The other port's wr_en is 0 that cycle.
  - Payload registers hold their last value when wr_en = 0.
- Core writes with mesi != I also clear the LST reservation bit. Requesters must not issue redundant writes.

## Timing
- Reset (async): all outputs 0, rr_ptr = 0, starve_cnt = 0, and all ready = 0 while rst is high.
- Latency: grant in cycle N → LST write enable asserted in cycle N+1 → LST state visible from N+2.
- Throughput: one write per cycle in total.
- Back-to-back grants to the same requester are allowed when it is the only valid requester.
- rst asserted mid-operation: the registered write is dropped. Requesters must re-issue after reset.

## Structure
- The MESI encoding (I = 2'd0, S, E, M) and the L1D set/way count constants live in rvh_l1d_pkg. This block imports them; it does not redefine them.
- Sub-module rvh_l1d_rr_arb: parametrised REQ_NUM round-robin picker with a one-hot grant and pointer update. It is reusable by other L1D arbiters.
- Top level: priority/starvation logic, output registers, busy.

## Test plan
- Single core request: req_valid = 3'b001, set 5, way 2, mesi M. Expect req_ready = 001 that cycle. Next cycle lst_mesi_wr_en_s0_req = 1 with set 5, way 2, dat 2'd3, and lst_mesi_wr_en_snp = 0.
- Round-robin: req_valid = 3'b111 held for 6 cycles, no snoop. Expect grants 0, 1, 2, 0, 1, 2.
- Starvation: snp_valid and req_valid[1] held high. Expect 4 snoop grants, then 1 core grant, then 4 snoop grants. Only one wr_en is high per cycle.
- Collision: snoop and req[0] both target set 10, way 1. Expect snoop written first, core written the next cycle, final LST state = the core mesi.
- Reset: assert rst in the cycle after a grant. Expect wr_en = 0 immediately, rr_ptr = 0, and the first post-reset grant with 3'b111 going to requester 0.

Source files
------------

// File: rtl/rvh_l1d_pkg.sv
// Shared L1D constants and MESI encoding.
package rvh_l1d_pkg;

   localparam int unsigned L1D_SET_NUM   = 64;
   localparam int unsigned L1D_WAY_NUM   = 4;
   localparam int unsigned L1D_SET_IDX_W = $clog2(L1D_SET_NUM);
   localparam int unsigned L1D_WAY_IDX_W = $clog2(L1D_WAY_NUM);
   localparam int unsigned MESI_W        = 2;

   typedef enum logic [MESI_W-1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_e;

endpackage

// File: rtl/rvh_l1d_rr_arb.sv
// Round-robin picker: one-hot grant, pointer advances past the winner on adv.
module rvh_l1d_rr_arb #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] gnt
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] gnt_idx_c;
   logic             found_c;

   // Search from ptr_q upward, wrapping modulo N; first valid requester wins.
   always_comb begin
      int unsigned idx;
      gnt       = '0;
      gnt_idx_c = '0;
      found_c   = 1'b0;
      idx       = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= N) idx = idx - N;
         if (!found_c && req[idx]) begin
            found_c   = 1'b1;
            gnt[idx]  = 1'b1;
            gnt_idx_c = PTR_W'(idx);
         end
      end
   end

   // Pointer moves to the requester after the winner only when the grant is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (adv && found_c) begin
         ptr_q <= (gnt_idx_c == PTR_W'(N - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
      end
   end

endmodule

// File: rtl/rvh_l1d_lst_wr_sched.sv
// LST MESI write scheduler: snoop-priority with bounded core starvation,
// round-robin across core requesters, one LST write enable per cycle.
module rvh_l1d_lst_wr_sched
   import rvh_l1d_pkg::*;
#(
   parameter int unsigned REQ_NUM    = 3,
   parameter int unsigned SET_IDX_W  = L1D_SET_IDX_W,
   parameter int unsigned WAY_IDX_W  = L1D_WAY_IDX_W,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [REQ_NUM-1:0]             req_valid,
   output logic [REQ_NUM-1:0]             req_ready,
   input  logic [REQ_NUM*SET_IDX_W-1:0]   req_set_idx,
   input  logic [REQ_NUM*WAY_IDX_W-1:0]   req_way_idx,
   input  logic [REQ_NUM*MESI_W-1:0]      req_mesi,
   input  logic                           snp_valid,
   output logic                           snp_ready,
   input  logic [SET_IDX_W-1:0]           snp_set_idx,
   input  logic [WAY_IDX_W-1:0]           snp_way_idx,
   input  logic [MESI_W-1:0]              snp_mesi,
   output logic                           lst_mesi_wr_en_s0_req,
   output logic [SET_IDX_W-1:0]           lst_mesi_wr_set_idx_s0_req,
   output logic [WAY_IDX_W-1:0]           lst_mesi_wr_way_idx_s0_req,
   output logic [MESI_W-1:0]              lst_mesi_wr_dat_s0_req,
   output logic                           lst_mesi_wr_en_snp,
   output logic [SET_IDX_W-1:0]           lst_mesi_wr_set_idx_snp,
   output logic [WAY_IDX_W-1:0]           lst_mesi_wr_way_idx_snp,
   output logic [MESI_W-1:0]              lst_mesi_wr_dat_snp,
   output logic                           sched_busy
);

   localparam int unsigned STARVE_W = 3;

   logic [STARVE_W-1:0]  starve_cnt_q;
   logic                 any_req_c;
   logic                 snp_win_c;
   logic                 core_gnt_c;
   logic [REQ_NUM-1:0]   arb_gnt_c;
   logic [SET_IDX_W-1:0] sel_set_c;
   logic [WAY_IDX_W-1:0] sel_way_c;
   logic [MESI_W-1:0]    sel_mesi_c;

   rvh_l1d_rr_arb #(
      .N (REQ_NUM)
   ) u_rr_arb (
      .clk (clk),
      .rst (rst),
      .req (req_valid),
      .adv (core_gnt_c),
      .gnt (arb_gnt_c)
   );

   // Snoop wins unless a core request has already waited STARVE_MAX snoop grants.
   always_comb begin
      any_req_c  = |req_valid;
      snp_win_c  = snp_valid && (!any_req_c || (starve_cnt_q < STARVE_W'(STARVE_MAX)));
      core_gnt_c = any_req_c && !snp_win_c;
      snp_ready  = snp_win_c && !rst;
      req_ready  = (core_gnt_c && !rst) ? arb_gnt_c : '0;
   end

   // One-hot payload mux for the winning core requester.
   always_comb begin
      sel_set_c  = '0;
      sel_way_c  = '0;
      sel_mesi_c = '0;
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
         if (arb_gnt_c[k]) begin
            sel_set_c  = sel_set_c  | req_set_idx[k*SET_IDX_W +: SET_IDX_W];
            sel_way_c  = sel_way_c  | req_way_idx[k*WAY_IDX_W +: WAY_IDX_W];
            sel_mesi_c = sel_mesi_c | req_mesi[k*MESI_W +: MESI_W];
         end
      end
   end

   // Starvation counter: counts snoop wins over waiting core requests, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else if (core_gnt_c || !any_req_c) begin
         starve_cnt_q <= '0;
      end else if (snp_win_c && (starve_cnt_q != '1)) begin
         starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
      end
   end

   // Output stage: one-cycle write enables, payload held while idle.
   // Core writes with non-I state also drop the line reservation inside the LST.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lst_mesi_wr_en_s0_req      <= 1'b0;
         lst_mesi_wr_set_idx_s0_req <= '0;
         lst_mesi_wr_way_idx_s0_req <= '0;
         lst_mesi_wr_dat_s0_req     <= '0;
         lst_mesi_wr_en_snp         <= 1'b0;
         lst_mesi_wr_set_idx_snp    <= '0;
         lst_mesi_wr_way_idx_snp    <= '0;
         lst_mesi_wr_dat_snp        <= '0;
      end else begin
         lst_mesi_wr_en_s0_req <= core_gnt_c;
         lst_mesi_wr_en_snp    <= snp_win_c;
         if (core_gnt_c) begin
            lst_mesi_wr_set_idx_s0_req <= sel_set_c;
            lst_mesi_wr_way_idx_s0_req <= sel_way_c;
            lst_mesi_wr_dat_s0_req     <= sel_mesi_c;
         end
         if (snp_win_c) begin
            lst_mesi_wr_set_idx_snp <= snp_set_idx;
            lst_mesi_wr_way_idx_snp <= snp_way_idx;
            lst_mesi_wr_dat_snp     <= snp_mesi;
         end
      end
   end

   // Busy while anything is pending or a write is in flight.
   always_comb begin
      sched_busy = !rst && (any_req_c || snp_valid ||
                            lst_mesi_wr_en_s0_req || lst_mesi_wr_en_snp);
   end

endmodule

// File: tb/tb_rvh_l1d_lst_wr_sched.sv
// Self-checking bench for rvh_l1d_lst_wr_sched: directed scenarios plus
// random traffic against a transaction-level reference model.
module tb_rvh_l1d_lst_wr_sched;

   localparam int REQ_NUM    = 3;
   localparam int SW         = 6;
   localparam int WW         = 2;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [REQ_NUM-1:0]    req_valid = '0;
   logic [REQ_NUM-1:0]    req_ready;
   logic [REQ_NUM*SW-1:0] req_set_idx;
   logic [REQ_NUM*WW-1:0] req_way_idx;
   logic [REQ_NUM*2-1:0]  req_mesi;
   logic                  snp_valid = 1'b0;
   logic                  snp_ready;
   logic [SW-1:0]         snp_set_idx = '0;
   logic [WW-1:0]         snp_way_idx = '0;
   logic [1:0]            snp_mesi = '0;
   logic                  en_s0, en_snp, busy;
   logic [SW-1:0]         set_s0, set_snp;
   logic [WW-1:0]         way_s0, way_snp;
   logic [1:0]            dat_s0, dat_snp;

   logic [SW-1:0] r_set  [REQ_NUM];
   logic [WW-1:0] r_way  [REQ_NUM];
   logic [1:0]    r_mesi [REQ_NUM];

   always_comb begin
      for (int k = 0; k < REQ_NUM; k++) begin
         req_set_idx[k*SW +: SW] = r_set[k];
         req_way_idx[k*WW +: WW] = r_way[k];
         req_mesi[k*2 +: 2]      = r_mesi[k];
      end
   end

   rvh_l1d_lst_wr_sched #(
      .REQ_NUM    (REQ_NUM),
      .SET_IDX_W  (SW),
      .WAY_IDX_W  (WW),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .req_valid                  (req_valid),
      .req_ready                  (req_ready),
      .req_set_idx                (req_set_idx),
      .req_way_idx                (req_way_idx),
      .req_mesi                   (req_mesi),
      .snp_valid                  (snp_valid),
      .snp_ready                  (snp_ready),
      .snp_set_idx                (snp_set_idx),
      .snp_way_idx                (snp_way_idx),
      .snp_mesi                   (snp_mesi),
      .lst_mesi_wr_en_s0_req      (en_s0),
      .lst_mesi_wr_set_idx_s0_req (set_s0),
      .lst_mesi_wr_way_idx_s0_req (way_s0),
      .lst_mesi_wr_dat_s0_req     (dat_s0),
      .lst_mesi_wr_en_snp         (en_snp),
      .lst_mesi_wr_set_idx_snp    (set_snp),
      .lst_mesi_wr_way_idx_snp    (way_snp),
      .lst_mesi_wr_dat_snp        (dat_snp),
      .sched_busy                 (busy)
   );

   // Reference model state
   int          m_rr, m_starve;
   logic        e_en_s0, e_en_snp;
   logic [SW-1:0] e_set_s0, e_set_snp;
   logic [WW-1:0] e_way_s0, e_way_snp;
   logic [1:0]    e_dat_s0, e_dat_snp;
   int          last_core;
   bit          last_snp;
   logic [REQ_NUM-1:0] obs_req_ready;
   logic        obs_snp_ready;
   logic [1:0]  lst [64][4];

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_starve = 0;
      e_en_s0 = 0; e_en_snp = 0;
      e_set_s0 = '0; e_way_s0 = '0; e_dat_s0 = '0;
      e_set_snp = '0; e_way_snp = '0; e_dat_snp = '0;
      last_core = -1; last_snp = 0;
   endtask

   // Assert reset right now; outputs and grants must drop immediately.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_eq("rst_en_s0", 32'(en_s0), 0);
      check_eq("rst_en_snp", 32'(en_snp), 0);
      check_eq("rst_req_ready", 32'(req_ready), 0);
      check_eq("rst_snp_ready", 32'(snp_ready), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_payload", {set_s0, way_s0, dat_s0, set_snp, way_snp, dat_snp}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One cycle: check grants against the model, clock, then check the write ports.
   task automatic step();
      bit sg;
      int k;
      logic [REQ_NUM-1:0] exp_rdy;
      #1;
      sg = snp_valid && (req_valid == 0 || m_starve < STARVE_MAX);
      k = -1;
      if (!sg && req_valid != 0) begin
         for (int i = 0; i < REQ_NUM; i++) begin
            int c;
            c = (m_rr + i) % REQ_NUM;
            if (k < 0 && req_valid[c]) k = c;
         end
      end
      exp_rdy = (k >= 0) ? REQ_NUM'(1 << k) : '0;
      obs_req_ready = req_ready;
      obs_snp_ready = snp_ready;
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("snp_ready", 32'(snp_ready), 32'(sg));
      check_eq("busy", 32'(busy), 32'((req_valid != 0) || snp_valid || e_en_s0 || e_en_snp));
      @(posedge clk);
      e_en_s0 = (k >= 0);
      e_en_snp = sg;
      if (k >= 0) begin
         e_set_s0 = r_set[k]; e_way_s0 = r_way[k]; e_dat_s0 = r_mesi[k];
         m_rr = (k + 1) % REQ_NUM;
         m_starve = 0;
      end else if (req_valid == 0) begin
         m_starve = 0;
      end else if (sg && m_starve < 7) begin
         m_starve++;
      end
      if (sg) begin
         e_set_snp = snp_set_idx; e_way_snp = snp_way_idx; e_dat_snp = snp_mesi;
      end
      last_core = k;
      last_snp = sg;
      #1;
      check_eq("en_s0", 32'(en_s0), 32'(e_en_s0));
      check_eq("s0_payload", {set_s0, way_s0, dat_s0}, {e_set_s0, e_way_s0, e_dat_s0});
      check_eq("en_snp", 32'(en_snp), 32'(e_en_snp));
      check_eq("snp_payload", {set_snp, way_snp, dat_snp}, {e_set_snp, e_way_snp, e_dat_snp});
      check_eq("one_wr_en", 32'(en_s0 & en_snp), 0);
      if (en_snp) lst[set_snp][way_snp] = dat_snp;
      if (en_s0)  lst[set_s0][way_s0]   = dat_s0;
   endtask

   initial begin
      logic [REQ_NUM-1:0] exp_seq;
      string pat;
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 4; w++) lst[s][w] = 2'd0;
      for (int k = 0; k < REQ_NUM; k++) begin
         r_set[k] = '0; r_way[k] = '0; r_mesi[k] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      req_valid = 3'b111;
      snp_valid = 1'b1;
      do_reset();
      req_valid = '0;
      snp_valid = 1'b0;

      // Single core request
      r_set[0] = 6'd5; r_way[0] = 2'd2; r_mesi[0] = 2'd3;
      req_valid = 3'b001;
      step();
      check_eq("t1_ready", 32'(obs_req_ready), 32'h1);
      check_eq("t1_en_s0", 32'(en_s0), 1);
      check_eq("t1_set", 32'(set_s0), 5);
      check_eq("t1_way", 32'(way_s0), 2);
      check_eq("t1_dat", 32'(dat_s0), 3);
      check_eq("t1_en_snp", 32'(en_snp), 0);
      req_valid = '0;
      step();
      check_eq("t1_hold_set", 32'(set_s0), 5);

      // Round-robin over all three requesters
      do_reset();
      for (int k = 0; k < REQ_NUM; k++) begin
         r_set[k] = 6'(k + 1); r_way[k] = 2'(k); r_mesi[k] = 2'(k + 1);
      end
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         step();
         exp_seq = REQ_NUM'(1 << (i % 3));
         check_eq($sformatf("rr_grant%0d", i), 32'(obs_req_ready), 32'(exp_seq));
      end
      req_valid = '0;
      step();

      // Starvation bound: 4 snoops, 1 core, 4 snoops
      do_reset();
      pat = "SSSSCSSSS";
      snp_valid = 1'b1; snp_set_idx = 6'd33; snp_way_idx = 2'd3; snp_mesi = 2'd1;
      r_set[1] = 6'd7; r_way[1] = 2'd1; r_mesi[1] = 2'd2;
      req_valid = 3'b010;
      for (int i = 0; i < 9; i++) begin
         step();
         if (pat[i] == "S") check_eq($sformatf("starve_snp%0d", i), {obs_snp_ready, obs_req_ready}, 32'h8);
         else               check_eq($sformatf("starve_core%0d", i), {obs_snp_ready, obs_req_ready}, 32'h2);
      end
      snp_valid = 1'b0; req_valid = '0;
      step();

      // Same set/way collision: snoop first, then core
      do_reset();
      snp_set_idx = 6'd10; snp_way_idx = 2'd1; snp_mesi = 2'd1;
      r_set[0] = 6'd10; r_way[0] = 2'd1; r_mesi[0] = 2'd3;
      snp_valid = 1'b1; req_valid = 3'b001;
      step();
      check_eq("col_first_snp", {en_snp, en_s0}, 32'h2);
      check_eq("col_lst_mid", 32'(lst[10][1]), 1);
      snp_valid = 1'b0;
      step();
      check_eq("col_second_core", {en_snp, en_s0}, 32'h1);
      req_valid = '0;
      step();
      check_eq("col_lst_final", 32'(lst[10][1]), 3);

      // Reset right after a grant drops the write and restarts the pointer
      do_reset();
      req_valid = 3'b001;
      step();
      check_eq("mid_pre_en", 32'(en_s0), 1);
      req_valid = 3'b111;
      do_reset();
      step();
      check_eq("mid_post_grant", 32'(obs_req_ready), 32'h1);
      req_valid = '0;
      step();

      // Random traffic with valid held until granted
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < REQ_NUM; k++) begin
            if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
               req_valid[k] = 1'b1;
               r_set[k] = 6'($urandom); r_way[k] = 2'($urandom); r_mesi[k] = 2'($urandom);
            end
         end
         if (!snp_valid && $urandom_range(0, 3) != 0) begin
            snp_valid = 1'b1;
            snp_set_idx = 6'($urandom); snp_way_idx = 2'($urandom); snp_mesi = 2'($urandom);
         end
         step();
         if (last_core >= 0) req_valid[last_core] = 1'b0;
         if (last_snp) snp_valid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
